dmem_split_ctrl: RTL
====================

DMEM_SPLIT_CTRL -- requirements
Module: dmem_split_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the data width; only 32 is supported.
REQ-002 Parameter ADRS_WIDTH, default 32, SHALL set the byte address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mean a request is offered; req_ready  out  1  SHALL mean the request is accepted this cycle.
REQ-006 req_adrs  in  ADRS_WIDTH  SHALL carry the byte address; req_wr  in  1  SHALL select write (1) or read (0).
REQ-007 req_size  in  2  SHALL encode 00 byte, 01 halfword, 10 word, 11 illegal; req_sign_ext  in  1  SHALL select sign (1) or zero (0) extension for reads.
REQ-008 req_wr_data  in  WORD_WIDTH  SHALL carry LSB-aligned store data.
REQ-009 rsp_valid  out  1, rsp_ready  in  1, rsp_rd_data  out  WORD_WIDTH (LSB-aligned, extended), rsp_err  out  1 SHALL form the response channel.
REQ-010 mem_adrs  out  ADRS_WIDTH (bits [1:0] always 00), mem_rden  out  1, mem_wren  out  1, mem_byt_en  out  4, mem_wr_data  out  WORD_WIDTH, mem_rd_data  in  WORD_WIDTH SHALL drive a word-aligned data memory whose read data is combinational and whose write commits on the clock edge.

Function
REQ-011 FSM states SHALL be IDLE, ACC0, ACC1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 IDLE with req_valid SHALL register the request and go to ACC0; an illegal size or (without the macro) a word-crossing access SHALL go directly to RESP with rsp_err=1 and rsp_rd_data=0, with no memory access.
REQ-013 A crossing access SHALL satisfy offset + bytes(size) > 4, with offset = adrs[1:0].
REQ-014 Lane mapping SHALL form 64-bit data {hi,lo} = wr_data << (8*offset) and 8-bit enables = size mask << offset; ACC0 SHALL use the lo half at word address adrs[ADRS_WIDTH-1:2], and ACC1 SHALL use the hi half at word address +1, modulo 2^(ADRS_WIDTH-2).
REQ-015 ACC0 SHALL assert mem_rden (read) or mem_wren (write) for exactly one cycle and capture mem_rd_data into lo_q; it SHALL then go to ACC1 if the access crosses, else to RESP.
REQ-016 ACC1 SHALL assert one access at word+1, capture hi_q, and go to RESP.
REQ-017 RESP SHALL assert rsp_valid with rsp_rd_data = extend(({hi_q,lo_q} >> 8*offset) masked to size); it SHALL hold all response outputs stable until rsp_ready, then go to IDLE.
REQ-018 Writes SHALL return rsp_rd_data=0; mem_byt_en SHALL be 0 whenever no access is issued.
REQ-019 Latency from acceptance SHALL be: rsp_valid two cycles later for non-crossing accesses, three cycles later for crossing accesses, and one cycle later for errors.
REQ-020 A new request SHALL NOT be accepted in the cycle rsp_valid&rsp_ready occurs; the earliest next acceptance is the following cycle.

Reset
REQ-021 While rst=1, state SHALL go to IDLE at the next edge, and req_ready, rsp_valid, rsp_err, mem_rden, mem_wren and mem_byt_en SHALL be 0; rsp_rd_data SHALL be 0; lo_q and hi_q SHALL be cleared.
REQ-022 Reset between ACC0 and ACC1 of a split write SHALL leave the first word written, with no rollback, and SHALL suppress the second access.

Configuration
REQ-023 With DMEM_SPLIT_MISALIGN_EN defined, crossing accesses SHALL be split into ACC0 and ACC1; without it, ACC1 SHALL be absent and crossing accesses SHALL return rsp_err=1 per REQ-012.

Structure
REQ-024 Package dmem_ctrl_pkg SHALL hold the size encoding enum, the FSM state enum and the BYTES_PER_WORD=4 constant.
REQ-025 Sub-module dmem_lane_align (combinational) SHALL perform the REQ-014 write shift and mask and the REQ-017 read shift and extension.

Verification
REQ-026 Aligned word write 0xDEADBEEF to 0x10, then read at 0x10 -> one write with mem_byt_en=1111 at mem_adrs 0x10; read rsp_rd_data=0xDEADBEEF two cycles after acceptance.
REQ-027 Byte read at 0x13 of word 0x80FF0000, with sign_ext=1 then sign_ext=0 -> rsp_rd_data=0xFFFFFF80, then 0x00000080.
REQ-028 With the macro, halfword write 0xA55A at 0x13 -> ACC0 to 0x10 with byt_en=1000 and data[31:24]=0x5A; ACC1 to 0x14 with byt_en=0001 and data[7:0]=0xA5; halfword read at 0x13 returns 0x0000A55A after three cycles.
REQ-029 Without the macro, the same access -> no mem_rden/mem_wren; rsp_err=1 one cycle after acceptance.
REQ-030 Word read at 0xFFFFFFFE with the macro -> accesses to 0xFFFFFFFC and then 0x00000000 (wrap).
REQ-031 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable and req_ready=0 throughout; rst asserted in ACC0 -> IDLE next edge with all outputs 0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl_pkg
//  Description : Shared types and helpers for the data-memory split
//                controller: access-size encoding, controller FSM states,
//                and the per-size byte count / byte-lane mask helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Number of bytes touched by an access; 0 for the illegal encoding.
    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

    // LSB-aligned byte-lane mask for an access of the given size.
    function automatic logic [3:0] size_mask(input size_e size);
        case (size)
            SIZE_BYTE: size_mask = 4'b0001;
            SIZE_HALF: size_mask = 4'b0011;
            SIZE_WORD: size_mask = 4'b1111;
            default:   size_mask = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational byte-lane steering for the split controller.
//                Write side: shifts LSB-aligned store data and the size mask
//                up by the byte offset into a two-word window {hi, lo}.
//                Read side: shifts the captured two-word window down by the
//                byte offset, keeps the bytes of the access size and
//                sign/zero-extends the result.
//  Ports       : i_offset   byte offset within the first word
//                i_size     access size encoding
//                i_sign_ext 1 = sign extend reads, 0 = zero extend
//                i_wr_data  LSB-aligned store data
//                i_rd_lo    word read at the first word address
//                i_rd_hi    word read at the following word address
//                o_wr_lo/o_wr_hi  store data for first / second word
//                o_en_lo/o_en_hi  byte enables for first / second word
//                o_rd_data  LSB-aligned, extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  size_e       i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_rd_lo,
    input  logic [31:0] i_rd_hi,
    output logic [31:0] o_wr_lo,
    output logic [31:0] o_wr_hi,
    output logic [3:0]  o_en_lo,
    output logic [3:0]  o_en_hi,
    output logic [31:0] o_rd_data
);

    logic [4:0]  w_shift;
    logic [5:0]  w_shift_hi;
    logic [63:0] w_wr_wide;
    logic [7:0]  w_en_wide;
    logic [31:0] w_rd_sel;

    always_comb begin
        w_shift    = {i_offset, 3'b000};
        w_wr_wide  = {32'h0, i_wr_data} << w_shift;
        w_en_wide  = {4'h0, size_mask(i_size)} << i_offset;

        // Low 32 bits of ({hi,lo} >> shift). A shift of 32 yields zero, so
        // offset 0 takes nothing from the high word.
        w_shift_hi = 6'd32 - {1'b0, w_shift};
        w_rd_sel   = (i_rd_lo >> w_shift) | (i_rd_hi << w_shift_hi);

        case (i_size)
            SIZE_BYTE: o_rd_data = {{24{i_sign_ext & w_rd_sel[7]}},  w_rd_sel[7:0]};
            SIZE_HALF: o_rd_data = {{16{i_sign_ext & w_rd_sel[15]}}, w_rd_sel[15:0]};
            SIZE_WORD: o_rd_data = w_rd_sel;
            default:   o_rd_data = 32'h0;
        endcase
    end

    assign o_wr_lo = w_wr_wide[31:0];
    assign o_wr_hi = w_wr_wide[63:32];
    assign o_en_lo = w_en_wide[3:0];
    assign o_en_hi = w_en_wide[7:4];

endmodule
`default_nettype wire

// File: rtl/dmem_split_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_split_ctrl
//  Description : Data-memory access controller. Accepts one byte/halfword/
//                word request at a time, drives a word-aligned memory with
//                combinational read data, and returns an LSB-aligned,
//                extended response. Accesses that cross a word boundary are
//                split into two memory cycles when DMEM_SPLIT_MISALIGN_EN is
//                defined; otherwise they complete with an error and no
//                memory access. Illegal sizes always complete with an error.
//  Build macro : DMEM_SPLIT_MISALIGN_EN (undefined = crossing accesses error)
//  Ports       : clk, rst (synchronous, active high)
//                req_*  request channel (valid/ready, adrs, wr, size,
//                       sign_ext, wr_data)
//                rsp_*  response channel (valid/ready, rd_data, err)
//                mem_*  word-aligned memory port (adrs, rden, wren, byt_en,
//                       wr_data, rd_data)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_split_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADRS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADRS_WIDTH-1:0] req_adrs,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_sign_ext,
    input  logic [WORD_WIDTH-1:0] req_wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_rd_data,
    output logic                  rsp_err,
    output logic [ADRS_WIDTH-1:0] mem_adrs,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [3:0]            mem_byt_en,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    input  logic [WORD_WIDTH-1:0] mem_rd_data
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADRS_WIDTH-1:0] r_adrs;
    logic                  r_wr;
    size_e                 r_size;
    logic                  r_sign_ext;
    logic [WORD_WIDTH-1:0] r_wr_data;
    logic                  r_err;
    logic [WORD_WIDTH-1:0] r_lo_q;
    logic [WORD_WIDTH-1:0] r_hi_q;
`ifdef DMEM_SPLIT_MISALIGN_EN
    logic                  r_cross;
`endif

    logic                  w_accept;
    logic                  w_req_illegal;
    logic                  w_req_cross;
    logic                  w_req_err;
    logic                  w_acc0;
    logic                  w_acc1;
    logic [ADRS_WIDTH-3:0] w_word;
    logic [WORD_WIDTH-1:0] w_wr_lo;
    logic [WORD_WIDTH-1:0] w_wr_hi;
    logic [3:0]            w_en_lo;
    logic [3:0]            w_en_hi;
    logic [WORD_WIDTH-1:0] w_rd_ext;

    // ------------------------------------------------------------------
    // Request classification (evaluated on the offered request)
    // ------------------------------------------------------------------
    assign w_accept      = req_valid && (r_state == ST_IDLE);
    assign w_req_illegal = (req_size == SIZE_ILLEGAL);
    assign w_req_cross   = ({1'b0, req_adrs[1:0]} + size_bytes(size_e'(req_size)))
                           > 3'(BYTES_PER_WORD);
`ifdef DMEM_SPLIT_MISALIGN_EN
    assign w_req_err     = w_req_illegal;
`else
    assign w_req_err     = w_req_illegal || w_req_cross;
`endif

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_adrs     <= '0;
            r_wr       <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_sign_ext <= 1'b0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
            r_lo_q     <= '0;
            r_hi_q     <= '0;
`ifdef DMEM_SPLIT_MISALIGN_EN
            r_cross    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_adrs     <= req_adrs;
                r_wr       <= req_wr;
                r_size     <= size_e'(req_size);
                r_sign_ext <= req_sign_ext;
                r_wr_data  <= req_wr_data;
                r_err      <= w_req_err;
`ifdef DMEM_SPLIT_MISALIGN_EN
                r_cross    <= w_req_cross;
`endif
            end
            if (r_state == ST_ACC0) r_lo_q <= mem_rd_data;
            if (r_state == ST_ACC1) r_hi_q <= mem_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) w_state_nxt = w_req_err ? ST_RESP : ST_ACC0;
            end
            ST_ACC0: begin
`ifdef DMEM_SPLIT_MISALIGN_EN
                w_state_nxt = r_cross ? ST_ACC1 : ST_RESP;
`else
                w_state_nxt = ST_RESP;
`endif
            end
            ST_ACC1: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane steering
    // ------------------------------------------------------------------
    dmem_lane_align u_lane_align (
        .i_offset   (r_adrs[1:0]),
        .i_size     (r_size),
        .i_sign_ext (r_sign_ext),
        .i_wr_data  (r_wr_data),
        .i_rd_lo    (r_lo_q),
        .i_rd_hi    (r_hi_q),
        .o_wr_lo    (w_wr_lo),
        .o_wr_hi    (w_wr_hi),
        .o_en_lo    (w_en_lo),
        .o_en_hi    (w_en_hi),
        .o_rd_data  (w_rd_ext)
    );

    // ------------------------------------------------------------------
    // Outputs. Everything is qualified with !rst so that an access in
    // flight is squashed in the very cycle reset is raised: a split write
    // interrupted after its first word keeps that word, and the second
    // word is never issued.
    // ------------------------------------------------------------------
    assign w_acc0 = !rst && (r_state == ST_ACC0);
    assign w_acc1 = !rst && (r_state == ST_ACC1);

    // The second word address wraps modulo the word-address space.
    assign w_word = r_adrs[ADRS_WIDTH-1:2] + {{(ADRS_WIDTH-3){1'b0}}, (r_state == ST_ACC1)};

    always_comb begin
        req_ready   = !rst && (r_state == ST_IDLE);
        mem_adrs    = {w_word, 2'b00};
        mem_rden    = (w_acc0 || w_acc1) && !r_wr;
        mem_wren    = (w_acc0 || w_acc1) &&  r_wr;
        mem_byt_en  = 4'b0000;
        if (w_acc0) mem_byt_en = w_en_lo;
        if (w_acc1) mem_byt_en = w_en_hi;
        mem_wr_data = (r_state == ST_ACC1) ? w_wr_hi : w_wr_lo;

        // Response fields derive only from registers, so they stay stable
        // for as long as the response is held off by rsp_ready.
        rsp_valid   = !rst && (r_state == ST_RESP);
        rsp_err     = rsp_valid && r_err;
        rsp_rd_data = (rsp_valid && !r_wr && !r_err) ? w_rd_ext : '0;
    end

endmodule
`default_nettype wire
